// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, talks req/gnt/rvalid to imem and
// queues returned words in order for the fetch-to-decode register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Stall_En,
  input  logic        Redirect_En,
  input  logic [31:0] Redirect_PC,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Gnt,
  input  logic        IMem_RValid,
  input  logic [31:0] IMem_RData,
  output logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] PC_Plus_4_F,
  output logic        Valid_F
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] DEPTH = OW'(BUF_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          fifo_q [BUF_DEPTH];
  entry_t          head;
  logic [31:0]     fetch_pc;
  logic [31:0]     req_pc;
  logic            outstanding;
  logic            discard;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            push;
  logic            pop;
  logic            grant;
  logic            out_after;
  logic [OW-1:0]   occ;
  logic            unused_bits;

  assign unused_bits = ^Redirect_PC[1:0];

  // A response only counts if it answers a request we still care about.
  assign push = IMem_RValid && outstanding
              && !discard && !Redirect_En;
  assign pop  = Valid_F && !Stall_En && !Redirect_En;

  assign out_after = outstanding && !IMem_RValid;

  // Occupancy reserves a slot for the in-flight word.
  assign occ = OW'(count) + OW'(push)
             - OW'(pop) + OW'(out_after);

  assign IMem_Req = !Redirect_En
                  && (!outstanding || push)
                  && (occ < DEPTH);

  assign grant     = IMem_Req && IMem_Gnt;
  assign IMem_Addr = fetch_pc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else if (Redirect_En) begin
      fetch_pc    <= {Redirect_PC[31:2], 2'b00};
      outstanding <= out_after;
      discard     <= out_after;
    end else begin
      if (grant) begin
        fetch_pc    <= fetch_pc + 32'd4;
        req_pc      <= fetch_pc;
        outstanding <= 1'b1;
      end else if (IMem_RValid) begin
        outstanding <= 1'b0;
      end
      if (IMem_RValid) begin
        discard <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (Redirect_En) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_q[wr_ptr] <= '{pc: req_pc, instr: IMem_RData};
    end
  end

  assign head    = fifo_q[rd_ptr];
  assign Valid_F = (count != '0);

  always_comb begin
    Instr_F     = NOP_INSTR;
    PC_F        = '0;
    PC_Plus_4_F = '0;
    if (Valid_F) begin
      Instr_F     = head.instr;
      PC_F        = head.pc;
      PC_Plus_4_F = head.pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirect,
// reset and PC wrap, with a small latency-configurable imem model.
module tb_fetch_unit;

  localparam logic [31:0] K   = 32'hA5A50000;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, redir, gnt;
  logic [31:0] redir_pc;
  logic        req, valid, rvalid;
  logic [31:0] addr, rdata, instr, pc, pc4;
  logic        m_rv, f_rv, mem_on;
  logic [31:0] m_rd, f_rd;

  logic        rst_w;
  logic        stall_w = 1'b0;
  logic        redir_w = 1'b0;
  logic [31:0] redir_pc_w = 32'h0;
  logic        gnt_w = 1'b1;
  logic        req_w, valid_w, rv_w;
  logic [31:0] addr_w, rd_w, instr_w, pc_w, pc4_w;

  assign rvalid = mem_on ? m_rv : f_rv;
  assign rdata  = mem_on ? m_rd : f_rd;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .CLK(clk), .RST(rst),
    .Stall_En(stall), .Redirect_En(redir),
    .Redirect_PC(redir_pc),
    .IMem_Req(req), .IMem_Addr(addr),
    .IMem_Gnt(gnt), .IMem_RValid(rvalid),
    .IMem_RData(rdata),
    .Instr_F(instr), .PC_F(pc),
    .PC_Plus_4_F(pc4), .Valid_F(valid)
  );

  fetch_unit #(.RESET_PC(32'hFFFFFFF8)) dut_w (
    .CLK(clk), .RST(rst_w),
    .Stall_En(stall_w), .Redirect_En(redir_w),
    .Redirect_PC(redir_pc_w),
    .IMem_Req(req_w), .IMem_Addr(addr_w),
    .IMem_Gnt(gnt_w), .IMem_RValid(rv_w),
    .IMem_RData(rd_w),
    .Instr_F(instr_w), .PC_F(pc_w),
    .PC_Plus_4_F(pc4_w), .Valid_F(valid_w)
  );

  int n_run  = 0;
  int n_fail = 0;
  int lat    = 1;

  // imem model for the main instance
  bit          g_a, pend_a;
  int          left_a;
  logic [31:0] ad_a, pa_a;
  initial begin
    m_rv = 1'b0; m_rd = '0; pend_a = 0; left_a = 0;
  end
  always begin
    @(posedge clk);
    g_a  = req && gnt && !rst;
    ad_a = addr;
    #1;
    m_rv = 1'b0;
    if (rst) begin
      pend_a = 0;
    end else begin
      if (g_a) begin
        pend_a = 1; left_a = lat; pa_a = ad_a;
      end
      if (pend_a) begin
        left_a--;
        if (left_a == 0) begin
          m_rv = 1'b1; m_rd = pa_a ^ K; pend_a = 0;
        end
      end
    end
  end

  // imem model for the wrap instance: grant always, 1-cycle response
  logic [31:0] gq[$];
  bit          g_w;
  logic [31:0] ad_w;
  initial begin
    rv_w = 1'b0; rd_w = '0;
  end
  always begin
    @(posedge clk);
    g_w  = req_w && !rst_w;
    ad_w = addr_w;
    if (g_w) gq.push_back(ad_w);
    #1;
    rv_w = g_w && !rst_w;
    rd_w = ad_w ^ K;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic restart(input int l);
    rst = 1'b1; lat = l; stall = 1'b0; redir = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  logic [31:0] gv;
  bit          found;
  bit          seen;

  initial begin
    rst = 1'b1; stall = 1'b0; redir = 1'b0; gnt = 1'b1;
    redir_pc = '0; f_rv = 1'b0; f_rd = '0; mem_on = 1'b1;
    rst_w = 1'b1;

    // streaming after reset
    restart(1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc4, 32'h0);
    chk("c0_req", 32'(req), 32'd1);
    chk("c0_addr", addr, 32'h0);
    tick();
    chk("c1_valid", 32'(valid), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("str_valid", 32'(valid), 32'd1);
      chk("str_pc", pc, 32'(i * 4));
      chk("str_pc4", pc4, 32'(i * 4 + 4));
      chk("str_data", instr, 32'(i * 4) ^ K);
      if (i < 3) tick();
    end

    // async reset mid-stream, no clock edge
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_instr", instr, NOP);
    chk("arst_addr", addr, 32'h0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_pc4", pc4, 32'h0);
    mem_on = 1'b0; gnt = 1'b0;
    tick();
    rst = 1'b0;
    f_rv = 1'b1; f_rd = 32'hDEADBEEF;
    #1;
    chk("late_req", 32'(req), 32'd1);
    chk("late_addr", addr, 32'h0);
    tick();
    f_rv = 1'b0;
    #1;
    chk("late_nopush", 32'(valid), 32'd0);
    chk("hold_addr", addr, 32'h0);
    tick();
    chk("late_nopush2", 32'(valid), 32'd0);
    mem_on = 1'b1; gnt = 1'b1;

    // stall while streaming
    restart(1);
    tick(); tick(); tick();
    stall = 1'b1;
    #1;
    chk("stl_req3", 32'(req), 32'd0);
    chk("stl_pc3", pc, 32'h4);
    tick();
    chk("stl_req4", 32'(req), 32'd0);
    chk("stl_pc4", pc, 32'h4);
    tick();
    chk("stl_addr", addr, 32'hC);
    chk("stl_pc5", pc, 32'h4);
    tick();
    chk("stl_pc6", pc, 32'h4);
    chk("stl_req6", 32'(req), 32'd0);
    tick();
    stall = 1'b0;
    #1;
    chk("rel_pc7", pc, 32'h4);
    chk("rel_req7", 32'(req), 32'd1);
    tick();
    chk("rel_pc8", pc, 32'h8);
    tick();
    chk("rel_pc9", pc, 32'hC);
    chk("rel_data9", instr, 32'hC ^ K);

    // redirect with request for 0x8 in flight, 2-cycle latency
    restart(2);
    tick(); tick(); tick();
    chk("l2_pc3", pc, 32'h0);
    tick();
    chk("l2_valid4", 32'(valid), 32'd0);
    tick();
    chk("l2_pc5", pc, 32'h4);
    redir = 1'b1; redir_pc = 32'h100;
    #1;
    chk("rd_req", 32'(req), 32'd0);
    tick();
    redir = 1'b0;
    #1;
    chk("rd_valid", 32'(valid), 32'd0);
    chk("rd_addr", addr, 32'h100);
    chk("rd_discard_req", 32'(req), 32'd0);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (valid) found = 1;
    end
    chk("rd_found", 32'(found), 32'd1);
    chk("rd_pc", pc, 32'h100);
    chk("rd_data", instr, 32'h100 ^ K);

    // redirect + stall + response in one cycle
    restart(1);
    tick(); tick(); tick();
    redir = 1'b1; stall = 1'b1; redir_pc = 32'h203;
    #1;
    chk("rsr_req", 32'(req), 32'd0);
    tick();
    redir = 1'b0; stall = 1'b0;
    #1;
    chk("rsr_valid", 32'(valid), 32'd0);
    chk("rsr_addr", addr, 32'h200);
    chk("rsr_req_next", 32'(req), 32'd1);
    tick();
    chk("rsr_valid5", 32'(valid), 32'd0);
    tick();
    chk("rsr_pc", pc, 32'h200);
    chk("rsr_data", instr, 32'h200 ^ K);

    // PC wrap on the second instance
    gq.delete();
    rst_w = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid_w) begin
        chk("wrap_data", instr_w, pc_w ^ K);
        if (pc_w == 32'hFFFFFFF8)
          chk("wrap_pc4_f8", pc4_w, 32'hFFFFFFFC);
        if (pc_w == 32'hFFFFFFFC) begin
          chk("wrap_pc4_fc", pc4_w, 32'h0);
          seen = 1;
        end
      end
    end
    chk("wrap_seen", 32'(seen), 32'd1);
    chk("wrap_nreq", 32'(gq.size() >= 3), 32'd1);
    gv = (gq.size() > 0) ? gq[0] : 32'hx;
    chk("wrap_req0", gv, 32'hFFFFFFF8);
    gv = (gq.size() > 1) ? gq[1] : 32'hx;
    chk("wrap_req1", gv, 32'hFFFFFFFC);
    gv = (gq.size() > 2) ? gq[2] : 32'hx;
    chk("wrap_req2", gv, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sequence did not complete");
    $fatal(1);
  end

endmodule
